// File: rtl/fsm_vector_driver.sv
// Vector replay and check engine for the two-state Moore FSM under test.
// Holds a small table of {in, cs, ns, exp_out} vectors, replays them onto the
// FSM and compares the FSM's out against exp_out.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   wr_en/addr/data   table write port, honoured only while not busy
//   num_vec, start    run length (clamped to DEPTH) and run request
//   busy, done, pass  run status; done/pass hold until the next start
//   err_count         mismatches in the last run
//   first_err_idx     first mismatching vector index, 0 if none
//   dut_reset         synchronous reset pulse to the FSM
//   dut_in/cs/ns      vector fields driven to the FSM
//   dut_exp_out       expected-output field driven to the FSM
//   dut_out           FSM output under check
//
// Optional: define FSMDRV_STOP_ON_ERR_EN to end a run at the first mismatch.
module fsm_vector_driver #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [OUT_W+2:0] wr_data,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      err_count,
    output logic [AW-1:0]    first_err_idx,
    output logic             dut_reset,
    output logic             dut_in,
    output logic             dut_cs,
    output logic             dut_ns,
    output logic [OUT_W-1:0] dut_exp_out,
    input  logic [OUT_W-1:0] dut_out
);

    typedef enum logic [2:0] {
        IDLE,
        DRST,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [OUT_W+2:0] vec_mem [DEPTH];
    logic [AW:0]      count_q;
    logic [AW:0]      count_clamp;
    logic [AW-1:0]    idx_q;
    logic             accept;
    logic             mismatch;
    logic             last_vec;

    always_comb begin
        count_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
        accept      = start && ((state == IDLE) || (state == DONE));
        mismatch    = (dut_out != dut_exp_out);
        last_vec    = ({1'b0, idx_q} == (count_q - 1'b1));
    end

    assign busy      = (state == DRST) || (state == DRIVE) || (state == CHECK);
    assign dut_reset = (state == DRST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_nx = DRST;
            end
            DRST: begin
                state_nx = (count_q == '0) ? DONE : DRIVE;
            end
            DRIVE: begin
                state_nx = CHECK;
            end
            CHECK: begin
`ifdef FSMDRV_STOP_ON_ERR_EN
                state_nx = (mismatch || last_vec) ? DONE : DRIVE;
`else
                state_nx = last_vec ? DONE : DRIVE;
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) vec_mem[i] <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            dut_in        <= 1'b0;
            dut_cs        <= 1'b0;
            dut_ns        <= 1'b0;
            dut_exp_out   <= '0;
        end else begin
            // The table is frozen only while a run is active.
            if (wr_en && !busy && (int'(wr_addr) < DEPTH)) begin
                vec_mem[wr_addr] <= wr_data;
            end
            if (accept) begin
                count_q       <= count_clamp;
                err_count     <= '0;
                first_err_idx <= '0;
                done          <= 1'b0;
                pass          <= 1'b0;
            end
            if (state == DRST) begin
                idx_q <= '0;
            end
            if (state == DRIVE) begin
                {dut_in, dut_cs, dut_ns, dut_exp_out} <= vec_mem[idx_q];
            end
            if (state == CHECK) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (err_count == '0) first_err_idx <= idx_q;
                end
                if (!last_vec) idx_q <= idx_q + 1'b1;
            end
            // done/pass register one cycle after entering DONE.
            if ((state == DONE) && !accept) begin
                done <= 1'b1;
                pass <= (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_fsm_vector_driver.sv
// Self-checking bench for fsm_vector_driver: case table plus hand sequences,
// with queues of expected vectors and run results.
module tb_fsm_vector_driver;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int OUT_W = 4;
    localparam int VW    = OUT_W + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [VW-1:0]    wr_data = '0;
    logic [AW:0]      num_vec = '0;
    logic             start = 1'b0;
    logic             busy, done, pass, dut_reset;
    logic [AW:0]      err_count;
    logic [AW-1:0]    first_err_idx;
    logic             dut_in, dut_cs, dut_ns;
    logic [OUT_W-1:0] dut_exp_out, dut_out;

    // FSM stand-in: echoes exp_out, or outputs a forced value.
    logic             echo = 1'b1;
    logic [OUT_W-1:0] force_val = '0;
    assign dut_out = echo ? dut_exp_out : force_val;

    fsm_vector_driver #(.DEPTH(DEPTH), .AW(AW), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .dut_reset(dut_reset), .dut_in(dut_in), .dut_cs(dut_cs),
        .dut_ns(dut_ns), .dut_exp_out(dut_exp_out), .dut_out(dut_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW:0]      nv;
        logic             echo;
        logic [OUT_W-1:0] fv;
        int               cyc;
        int               err;
        int               first;
        logic             pass;
    } case_t;

    typedef struct {
        int   cyc;
        int   err;
        int   first;
        logic pass;
    } res_t;

    logic [VW-1:0] model [DEPTH];
    logic [VW-1:0] vq [$];
    res_t          rq [$];
    case_t         cases [4];
    int            n_vec = 0;
    int            n_mis = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic write_vec(input int a, input logic [VW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0 plain, 1 write entry 0 with start, 2 write during run,
    // 3 start pulse during run.
    task automatic run(input logic [AW:0] nv, input int cyc, input int err,
                       input int first, input logic pas, input int mode);
        int   drv;
        int   nb;
        int   nrst;
        logic got;
        res_t r;
        logic [VW-1:0] v;
        @(negedge clk);
        start   = 1'b1;
        num_vec = nv;
        if (mode == 1) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_data  = 7'h6A;
            model[0] = 7'h6A;
        end
        drv = (cyc - 2) / 2;
        for (int i = 0; i < drv; i++) vq.push_back(model[i]);
        rq.push_back('{cyc, err, first, pas});
        got  = 1'b0;
        nb   = 0;
        nrst = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                wr_en = 1'b0;
                chk("busy_on_start", int'(busy), 1);
                chk("done_cleared", int'(done), 0);
            end
            if (mode == 2 && k == 3) begin
                wr_en   = 1'b1;
                wr_addr = 4'd1;
                wr_data = 7'h7F;
            end
            if (mode == 2 && k == 4) wr_en = 1'b0;
            if (mode == 3 && k == 4) begin
                start   = 1'b1;
                num_vec = 5'd1;
            end
            if (mode == 3 && k == 5) start = 1'b0;
            if (dut_reset) begin
                nrst++;
            end else if (busy) begin
                nb++;
                if (nb % 2 == 0) begin
                    if (vq.size() == 0) begin
                        chk("extra_vector", 1, 0);
                    end else begin
                        v = vq.pop_front();
                        chk("vector", int'({dut_in, dut_cs, dut_ns, dut_exp_out}),
                            int'(v));
                    end
                end
            end
            if (done) begin
                got = 1'b1;
                r = rq.pop_front();
                chk("latency", k, r.cyc);
                chk("err_count", int'(err_count), r.err);
                chk("first_err_idx", int'(first_err_idx), r.first);
                chk("pass", int'(pass), int'(r.pass));
                chk("busy_in_done", int'(busy), 0);
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            if (rq.size() > 0) void'(rq.pop_front());
        end
        chk("missing_vectors", vq.size(), 0);
        vq.delete();
        chk("dut_reset_cycles", nrst, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        cases[0] = '{5'd4, 1'b1, 4'h0, 10, 0, 0, 1'b1};
`ifdef FSMDRV_STOP_ON_ERR_EN
        cases[1] = '{5'd4, 1'b0, 4'h0, 8, 1, 2, 1'b0};
`else
        cases[1] = '{5'd4, 1'b0, 4'h0, 10, 2, 2, 1'b0};
`endif
        cases[2] = '{5'd0, 1'b1, 4'h0, 2, 0, 0, 1'b1};
        cases[3] = '{5'd31, 1'b1, 4'h0, 34, 0, 0, 1'b1};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_dut_reset", int'(dut_reset), 0);
        chk("rst_vec", int'({dut_in, dut_cs, dut_ns, dut_exp_out}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        write_vec(0, 7'h00);
        write_vec(1, 7'h50);
        write_vec(2, 7'h35);
        write_vec(3, 7'h65);

        for (int c = 0; c < 4; c++) begin
            echo      = cases[c].echo;
            force_val = cases[c].fv;
            run(cases[c].nv, cases[c].cyc, cases[c].err,
                cases[c].first, cases[c].pass, 0);
        end
        echo = 1'b1;

        run(5'd1, 4, 0, 0, 1'b1, 1);
        run(5'd4, 10, 0, 0, 1'b1, 2);
        run(5'd2, 6, 0, 0, 1'b1, 0);
        run(5'd4, 10, 0, 0, 1'b1, 3);

        // Async reset during CHECK of vector 2.
        @(negedge clk);
        start   = 1'b1;
        num_vec = 5'd4;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err_count), 0);
        chk("mid_rst_vec", int'({dut_in, dut_cs, dut_ns, dut_exp_out}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        echo      = 1'b0;
        force_val = 4'h0;
        run(5'd16, 34, 0, 0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/fsm_vector_driver.md
Name: fsm_vector_driver

Overview:
Stimulus and check engine for the two-state Moore FSM block (ports in, cs, ns, exp_out, out, reset).
- Holds a small programmable table of transition vectors.
- Replays the vectors onto the FSM's inputs and compares the FSM's 4-bit out against each vector's expected value.
- Reports pass/fail, the error count and the index of the first failing vector.
- Sits beside the FSM in the bring-up/self-test wrapper and drives the FSM's synchronous reset.

Parameters:
DEPTH, 16, number of vector table entries
AW, 4, table index width; must satisfy 2**AW >= DEPTH
OUT_W, 4, width of exp_out/out

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  AW  table write index
wr_data  in  3+OUT_W  vector fields: {in, cs, ns, exp_out}, MSB = in
num_vec  in  AW+1  number of vectors to run; sampled on start
start  in  1  run request pulse
busy  out  1  high while a run is in progress
done  out  1  high after a run completes; held until next accepted start
pass  out  1  done and err_count==0
err_count  out  AW+1  mismatches in the last run
first_err_idx  out  AW  index of the first mismatching vector; 0 if none
dut_reset  out  1  synchronous reset to the FSM
dut_in, dut_cs, dut_ns  out  1 each  vector fields driven to the FSM
dut_exp_out  out  OUT_W  expected-output field driven to the FSM
dut_out  in  OUT_W  FSM output under check

Behaviour:
Reset values:
- All outputs 0, FSM in IDLE.
- All table entries cleared to 0.
- Registered num_vec cleared to 0.

Table writes:
- In IDLE, wr_en writes wr_data to entry wr_addr at the clock edge.
- wr_addr >= DEPTH: write ignored.
- wr_en while busy: ignored; the table is frozen during a run.

States:
- IDLE: start=1 latches min(num_vec, DEPTH), clears err_count, first_err_idx and done, then goes to DRST.
- DRST: one cycle with dut_reset=1. Clears the vector index to 0. Next state: DRIVE, or DONE if the latched count is 0.
- DRIVE: registers table[idx] onto dut_in/cs/ns/exp_out; dut_reset=0. Next state: CHECK.
- CHECK: compares dut_out with the registered exp_out.
  - On mismatch: err_count+1. If this is the first error, first_err_idx=idx.
  - If idx == count-1, go to DONE. Otherwise idx+1 and go to DRIVE.
- DONE: done=1 and busy=0. On the cycle start is accepted, go to DRST; otherwise stay.

Output and timing rules:
- busy=1 in DRST, DRIVE and CHECK.
- dut_* vector outputs hold their last value between runs.
- Latency: done rises 2 + 2*count cycles after the start edge.
- count 0: done after 2 cycles with pass=1.
- Write and start in the same IDLE cycle: the write lands, and the run uses the updated table, because DRIVE follows DRST.
- start while busy: ignored.
- reset_n low at any point, including mid-run: immediate return to IDLE with all outputs at reset values; the table is cleared.
- num_vec > DEPTH: clamped to DEPTH.
- err_count cannot overflow, since the AW+1 bit width holds DEPTH.

Optional Feature:
FSMDRV_STOP_ON_ERR_EN
- Defined: the first mismatch in CHECK goes directly to DONE. err_count=1 and first_err_idx = failing index; the remaining vectors are not driven.
- Undefined: all count vectors always run and every mismatch is counted.

Test Plan:
1. Load 4 vectors {0,0,0,4'h0}, {1,0,1,4'h0}, {0,1,1,4'h5}, {1,1,0,4'h5}; num_vec=4; FSM echoes exp_out -> done after 10 cycles, pass=1, err_count=0, dut_reset high exactly 1 cycle.
2. Same table with the FSM out forced to 4'h0 -> err_count=2, first_err_idx=2, pass=0. With FSMDRV_STOP_ON_ERR_EN: err_count=1, first_err_idx=2, done after 8 cycles.
3. num_vec=0 -> done 2 cycles after start, pass=1. num_vec=31 with DEPTH=16 -> exactly 16 vectors driven, done after 34 cycles.
4. wr_en to entry 0 and start in the same cycle -> first driven vector equals the new data. wr_en during a run -> table unchanged on the next run.
5. reset_n pulsed low during CHECK of vector 2 -> busy, done, err_count = 0 immediately; all entries read back 0 on the next run.
6. start pulsed while busy -> ignored; the run completes with its original count; a new start in DONE restarts with done cleared.
